// File: rtl/fft_reorder_if.sv
// fft_reorder_if: beat-parallel complex sample streams into and out of the reorder buffer
interface fft_reorder_if #(parameter int WIDTH = 13, parameter int NUM = 16, parameter int N = 512);
  localparam int BB = $clog2(N / NUM);
  logic valid_in;
  logic [NUM-1:0][WIDTH-1:0] din_i;
  logic [NUM-1:0][WIDTH-1:0] din_q;
  logic valid_out;
  logic [NUM-1:0][WIDTH-1:0] dout_i;
  logic [NUM-1:0][WIDTH-1:0] dout_q;
  logic [BB-1:0] beat_out;
  logic sof_out;
  logic eof_out;
  modport master (output valid_in, din_i, din_q, input valid_out, dout_i, dout_q, beat_out, sof_out, eof_out);
  modport slave (input valid_in, din_i, din_q, output valid_out, dout_i, dout_q, beat_out, sof_out, eof_out);
endinterface

// File: rtl/fft_reorder.sv
// fft_reorder: converts bit-reversed FFT frames to natural bin order using ping-pong banks
module fft_reorder #(
  parameter int WIDTH = 13,
  parameter int NUM = 16,
  parameter int N = 512
) (
  input logic clk,
  input logic rst,
  fft_reorder_if.slave bus
);
  localparam int BEATS = N / NUM;
  localparam int LB = $clog2(NUM);
  localparam int BB = $clog2(BEATS);
  typedef enum logic {IDLE, READ} state_t;
  state_t state;
  logic [2*WIDTH-1:0] mem [2][N];
  logic [2*WIDTH-1:0] rd_word [NUM];
  logic [BB-1:0] wr_beat, rd_beat;
  logic wr_bank, rd_bank;
  logic [1:0] full, full_now, full_next;
  logic wr_last, rd_last, go;
  function automatic logic [LB-1:0] rev_lane(input logic [LB-1:0] x);
    logic [LB-1:0] r;
    for (int i = 0; i < LB; i++) r[i] = x[LB-1-i];
    return r;
  endfunction
  function automatic logic [BB-1:0] rev_beat(input logic [BB-1:0] x);
    logic [BB-1:0] r;
    for (int i = 0; i < BB; i++) r[i] = x[BB-1-i];
    return r;
  endfunction
  // full_now sees the bank being completed this cycle so readout starts without a bubble
  always_comb begin
    wr_last = bus.valid_in && wr_beat == BB'(BEATS - 1);
    full_now = full | (wr_last ? 2'b01 << wr_bank : 2'b00);
    go = state == READ || full_now[rd_bank];
    rd_last = go && rd_beat == BB'(BEATS - 1);
    full_next = full_now & ~(rd_last ? 2'b01 << rd_bank : 2'b00);
    for (int l = 0; l < NUM; l++) rd_word[l] = mem[rd_bank][{rd_beat, LB'(l)}];
  end
  // bin address of lane l in beat b is bitrev(l) followed by bitrev(b)
  always_ff @(posedge clk) begin
    if (bus.valid_in)
      for (int l = 0; l < NUM; l++)
        mem[wr_bank][{rev_lane(LB'(l)), rev_beat(wr_beat)}] <= {bus.din_i[l], bus.din_q[l]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_beat <= '0;
      rd_beat <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      bus.valid_out <= 1'b0;
      bus.sof_out <= 1'b0;
      bus.eof_out <= 1'b0;
      bus.beat_out <= '0;
      bus.dout_i <= '0;
      bus.dout_q <= '0;
    end else begin
      full <= full_next;
      if (bus.valid_in) wr_beat <= wr_beat + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
      bus.valid_out <= go;
      bus.sof_out <= go && rd_beat == '0;
      bus.eof_out <= rd_last;
      bus.beat_out <= go ? rd_beat : '0;
      for (int l = 0; l < NUM; l++) begin
        bus.dout_i[l] <= go ? rd_word[l][2*WIDTH-1:WIDTH] : '0;
        bus.dout_q[l] <= go ? rd_word[l][WIDTH-1:0] : '0;
      end
      if (go) begin
        rd_beat <= rd_beat + 1'b1;
        rd_bank <= rd_last ? ~rd_bank : rd_bank;
        state <= (!rd_last || full_now[~rd_bank]) ? READ : IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: scenario table plus a frame-level reference model of the bit-reversal reorder
module tb_fft_reorder;
  localparam int W = 13;
  localparam int NUM = 16;
  localparam int N = 512;
  localparam int BEATS = N / NUM;
  typedef logic [NUM-1:0][W-1:0] beat_t;
  typedef struct {
    int cyc;
    int m;
    beat_t i;
    beat_t q;
  } exp_t;
  typedef struct {
    int frames;
    int gap;
    int pat;
    int rst_beats;
    int rst_tail;
    int exp_valid;
    int exp_sof;
    int exp_run;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  fft_reorder_if #(.WIDTH(W), .NUM(NUM), .N(N)) bus ();
  fft_reorder #(.WIDTH(W), .NUM(NUM), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int cyc = 0, cnt = 0, next_free = 0;
  int nvalid, nsof, run, maxrun, outf, cur_pat;
  logic [W-1:0] fr_i [N], fr_q [N], nat_i [N], nat_q [N];
  exp_t exp_q [$];
  vec_t vecs [9];
  function automatic int rev9(input int p);
    int r = 0;
    for (int i = 0; i < 9; i++) r = r * 2 + ((p >> i) & 1);
    return r;
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL cyc=%0d %s got %h want %h", cyc, name, act, want);
    end
  endtask
  // positions arrive in order b*NUM+l; the completed frame is emitted in bin order
  task automatic model(input bit r, input bit v, input beat_t di, input beat_t dq);
    exp_t e;
    int start;
    if (r) begin
      exp_q.delete();
      cnt = 0;
      next_free = 0;
    end else if (v) begin
      for (int l = 0; l < NUM; l++) begin
        fr_i[cnt*NUM+l] = di[l];
        fr_q[cnt*NUM+l] = dq[l];
      end
      cnt++;
      if (cnt == BEATS) begin
        cnt = 0;
        for (int p = 0; p < N; p++) begin
          nat_i[rev9(p)] = fr_i[p];
          nat_q[rev9(p)] = fr_q[p];
        end
        start = cyc > next_free ? cyc : next_free;
        for (int m = 0; m < BEATS; m++) begin
          e.cyc = start + m;
          e.m = m;
          for (int l = 0; l < NUM; l++) begin
            e.i[l] = nat_i[m*NUM+l];
            e.q[l] = nat_q[m*NUM+l];
          end
          exp_q.push_back(e);
        end
        next_free = start + BEATS;
      end
    end
  endtask
  task automatic check();
    exp_t e;
    beat_t hand;
    if (bus.valid_out) begin
      nvalid++;
      run++;
      if (run > maxrun) maxrun = run;
    end else run = 0;
    if (bus.sof_out) nsof++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("valid_out", 256'(bus.valid_out), 256'(1));
      chk("beat_out", 256'(bus.beat_out), 256'(e.m));
      chk("sof_out", 256'(bus.sof_out), 256'(e.m == 0));
      chk("eof_out", 256'(bus.eof_out), 256'(e.m == BEATS - 1));
      chk("dout_i", 256'(bus.dout_i), 256'(e.i));
      chk("dout_q", 256'(bus.dout_q), 256'(e.q));
      if (cur_pat == 0) begin
        for (int l = 0; l < NUM; l++) hand[l] = W'(e.m * NUM + l + outf);
        chk("natural_order_i", 256'(bus.dout_i), 256'(hand));
        if (e.m == BEATS - 1) outf++;
      end
    end else
      chk("idle_flags", {bus.valid_out, bus.sof_out, bus.eof_out}, 256'(0));
  endtask
  task automatic step(input bit r, input bit v, input beat_t di, input beat_t dq);
    rst = r;
    bus.valid_in = v;
    bus.din_i = di;
    bus.din_q = dq;
    @(posedge clk);
    cyc++;
    model(r, v, di, dq);
    @(negedge clk);
    check();
  endtask
  task automatic gen(input int pat, input int f, input int b, output beat_t di, output beat_t dq);
    for (int l = 0; l < NUM; l++) begin
      if (pat == 0) begin
        di[l] = W'(rev9(b * NUM + l) + f);
        dq[l] = -di[l];
      end else if (pat == 1) begin
        di[l] = ((l + b) & 1) ? 13'h0FFF : 13'h1000;
        dq[l] = ((l + b) & 1) ? 13'h1000 : 13'h0FFF;
      end else begin
        di[l] = W'($urandom);
        dq[l] = W'($urandom);
      end
    end
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, '0);
  endtask
  initial begin
    beat_t di, dq;
    int g;
    vecs[0] = '{0, 0, 0, -1, -1, 0, 0, 0};
    vecs[1] = '{1, 0, 0, -1, -1, 32, 1, 32};
    vecs[2] = '{2, 0, 0, -1, -1, 64, 2, 64};
    vecs[3] = '{1, 1, 0, -1, -1, 32, 1, 32};
    vecs[4] = '{1, 0, 0, 10, -1, 32, 1, 32};
    vecs[5] = '{1, 0, 1, -1, -1, 32, 1, 32};
    vecs[6] = '{3, -1, 2, -1, -1, 96, 3, 32};
    vecs[7] = '{1, 0, 2, -1, 4, 5, 1, 5};
    vecs[8] = '{4, 0, 2, -1, -1, 128, 4, 128};
    cur_pat = 2;
    repeat (3) step(1'b1, 1'b0, '0, '0);
    chk("rst_valid", 256'(bus.valid_out), 256'(0));
    chk("rst_sof_eof", {bus.sof_out, bus.eof_out}, 256'(0));
    chk("rst_beat", 256'(bus.beat_out), 256'(0));
    chk("rst_dout", {bus.dout_i, bus.dout_q}, 256'(0));
    for (int s = 0; s < 9; s++) begin
      nvalid = 0; nsof = 0; run = 0; maxrun = 0; outf = 0;
      cur_pat = vecs[s].pat;
      if (vecs[s].rst_beats >= 0) begin
        for (int b = 0; b < vecs[s].rst_beats; b++) begin
          gen(vecs[s].pat, 0, b, di, dq);
          step(1'b0, 1'b1, di, dq);
        end
        step(1'b1, 1'b0, '0, '0);
      end
      for (int f = 0; f < vecs[s].frames; f++)
        for (int b = 0; b < BEATS; b++) begin
          gen(vecs[s].pat, f, b, di, dq);
          step(1'b0, 1'b1, di, dq);
          g = vecs[s].gap < 0 ? int'($urandom_range(1, 3)) : vecs[s].gap;
          repeat (g) idle();
        end
      if (vecs[s].rst_tail >= 0) begin
        repeat (vecs[s].rst_tail) idle();
        step(1'b1, 1'b0, '0, '0);
      end
      repeat (40) idle();
      chk($sformatf("s%0d_valid_cycles", s), 256'(nvalid), 256'(vecs[s].exp_valid));
      chk($sformatf("s%0d_sof_count", s), 256'(nsof), 256'(vecs[s].exp_sof));
      chk($sformatf("s%0d_longest_run", s), 256'(maxrun), 256'(vecs[s].exp_run));
      chk($sformatf("s%0d_pending", s), 256'(exp_q.size()), 256'(0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
